// File: rtl/change_dispenser.sv
// Coin-hopper driver: queues single-cycle change requests and fires one solenoid at a time
// with a fixed pulse width and inter-coin gap, while tracking per-denomination inventory.
module change_dispenser #(
    parameter int PULSE_CYCLES = 3,
    parameter int GAP_CYCLES   = 2,
    parameter int QDEPTH       = 8,
    parameter int INV_W        = 8,
    parameter int INIT_COUNT   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nickel_req,
    input  logic             dime_req,
    input  logic             quarter_req,
    input  logic             restock,
    input  logic             err_clear,
    output logic             nickel_sol,
    output logic             dime_sol,
    output logic             quarter_sol,
    output logic             busy,
    output logic             queue_full,
    output logic             overflow_err,
    output logic             short_err,
    output logic [6:0]       shortfall_cents,
    output logic [INV_W-1:0] nickel_cnt,
    output logic [INV_W-1:0] dime_cnt,
    output logic [INV_W-1:0] quarter_cnt
);

    localparam int AW   = $clog2(QDEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [INV_W-1:0] INV_INIT   = INV_W'(INIT_COUNT);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2
    } coin_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_nextTimer;
    logic [2:0]       r_sol;
    logic [2:0]       w_nextSol;

    coin_t            r_mem [QDEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [INV_W-1:0] r_nickelCnt;
    logic [INV_W-1:0] r_dimeCnt;
    logic [INV_W-1:0] r_quarterCnt;
    logic             r_overflowErr;
    logic             r_shortErr;
    logic [6:0]       r_shortfall;

    logic             w_anyReq;
    logic             w_multiReq;
    coin_t            w_reqCoin;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_dropEvt;
    coin_t            w_headCoin;
    logic [INV_W-1:0] w_headInv;
    logic             w_fireNow;
    logic             w_shortEvt;
    logic [6:0]       w_coinValue;
    logic [6:0]       w_shortBase;
    logic [7:0]       w_shortSum;
    logic [6:0]       w_shortNext;

    assign w_anyReq   = nickel_req | dime_req | quarter_req;
    assign w_multiReq = (nickel_req & dime_req) | (nickel_req & quarter_req) | (dime_req & quarter_req);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push     = w_anyReq && (!w_full || w_pop);
    assign w_dropEvt  = w_multiReq || (w_anyReq && w_full && !w_pop);
    assign w_headCoin = r_mem[r_rptr];
    assign w_fireNow  = w_pop && (w_headInv != '0);
    assign w_shortEvt = w_pop && (w_headInv == '0);

    // Highest denomination wins when several requests collide.
    always_comb begin
        w_reqCoin = COIN_NICKEL;
        if (quarter_req) begin
            w_reqCoin = COIN_QUARTER;
        end else if (dime_req) begin
            w_reqCoin = COIN_DIME;
        end
    end

    always_comb begin
        w_headInv   = r_nickelCnt;
        w_coinValue = 7'd5;
        case (w_headCoin)
            COIN_DIME: begin
                w_headInv   = r_dimeCnt;
                w_coinValue = 7'd10;
            end
            COIN_QUARTER: begin
                w_headInv   = r_quarterCnt;
                w_coinValue = 7'd25;
            end
            default: begin
                w_headInv   = r_nickelCnt;
                w_coinValue = 7'd5;
            end
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        w_nextSol   = r_sol;
        case (r_state)
            S_IDLE: begin
                w_nextSol = 3'b000;
                if (w_fireNow) begin
                    w_nextState = S_FIRE;
                    w_nextTimer = PULSE_LOAD;
                    w_nextSol   = 3'b001 << w_headCoin;
                end
            end
            S_FIRE: begin
                if (r_timer == '0) begin
                    w_nextState = S_GAP;
                    w_nextTimer = GAP_LOAD;
                    w_nextSol   = 3'b000;
                end else begin
                    w_nextTimer = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                w_nextSol = 3'b000;
                if (r_timer == '0) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_nextTimer = r_timer - 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextTimer = '0;
                w_nextSol   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_sol   <= 3'b000;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
            r_sol   <= w_nextSol;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_reqCoin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Restock takes priority over a decrement landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nickelCnt  <= INV_INIT;
            r_dimeCnt    <= INV_INIT;
            r_quarterCnt <= INV_INIT;
        end else if (restock) begin
            r_nickelCnt  <= INV_INIT;
            r_dimeCnt    <= INV_INIT;
            r_quarterCnt <= INV_INIT;
        end else if (w_fireNow) begin
            case (w_headCoin)
                COIN_DIME:    r_dimeCnt    <= r_dimeCnt - 1'b1;
                COIN_QUARTER: r_quarterCnt <= r_quarterCnt - 1'b1;
                default:      r_nickelCnt  <= r_nickelCnt - 1'b1;
            endcase
        end
    end

    assign w_shortBase = err_clear ? 7'd0 : r_shortfall;
    assign w_shortSum  = {1'b0, w_shortBase} + {1'b0, w_coinValue};
    assign w_shortNext = (w_shortSum > 8'd127) ? 7'd127 : w_shortSum[6:0];

    // A new error event in the same cycle as err_clear survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflowErr <= 1'b0;
            r_shortErr    <= 1'b0;
            r_shortfall   <= 7'd0;
        end else begin
            if (w_dropEvt) begin
                r_overflowErr <= 1'b1;
            end else if (err_clear) begin
                r_overflowErr <= 1'b0;
            end
            if (w_shortEvt) begin
                r_shortErr  <= 1'b1;
                r_shortfall <= w_shortNext;
            end else if (err_clear) begin
                r_shortErr  <= 1'b0;
                r_shortfall <= 7'd0;
            end
        end
    end

    assign nickel_sol      = r_sol[0];
    assign dime_sol        = r_sol[1];
    assign quarter_sol     = r_sol[2];
    assign busy            = !w_empty || (r_state != S_IDLE);
    assign queue_full      = w_full;
    assign overflow_err    = r_overflowErr;
    assign short_err       = r_shortErr;
    assign shortfall_cents = r_shortfall;
    assign nickel_cnt      = r_nickelCnt;
    assign dime_cnt        = r_dimeCnt;
    assign quarter_cnt     = r_quarterCnt;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a default-parameter instance plus an INIT_COUNT=1
// instance used to exercise shortfall accounting and saturation.
module tb_change_dispenser;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] NREQ = 5'b00001;
    localparam logic [4:0] DREQ = 5'b00010;
    localparam logic [4:0] QREQ = 5'b00100;
    localparam logic [4:0] RSTK = 5'b01000;
    localparam logic [4:0] ECLR = 5'b10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] mainIn = NONE;
    logic [4:0] auxIn = NONE;

    logic       nickelSol, dimeSol, quarterSol, busy, queueFull, overflowErr, shortErr;
    logic [6:0] shortfallCents;
    logic [7:0] nickelCnt, dimeCnt, quarterCnt;

    logic       nickelSol2, dimeSol2, quarterSol2, busy2, queueFull2, overflowErr2, shortErr2;
    logic [6:0] shortfallCents2;
    logic [7:0] nickelCnt2, dimeCnt2, quarterCnt2;

    int vectors = 0;
    int miscompares = 0;
    int nPulses = 0;
    int dPulses = 0;
    int qPulses = 0;
    int q2Pulses = 0;
    logic prevN = 1'b0;
    logic prevD = 1'b0;
    logic prevQ = 1'b0;
    logic prevQ2 = 1'b0;

    change_dispenser dut (
        .clk(clk), .reset(reset),
        .nickel_req(mainIn[0]), .dime_req(mainIn[1]), .quarter_req(mainIn[2]),
        .restock(mainIn[3]), .err_clear(mainIn[4]),
        .nickel_sol(nickelSol), .dime_sol(dimeSol), .quarter_sol(quarterSol),
        .busy(busy), .queue_full(queueFull), .overflow_err(overflowErr), .short_err(shortErr),
        .shortfall_cents(shortfallCents),
        .nickel_cnt(nickelCnt), .dime_cnt(dimeCnt), .quarter_cnt(quarterCnt)
    );

    change_dispenser #(.INIT_COUNT(1)) dut2 (
        .clk(clk), .reset(reset),
        .nickel_req(auxIn[0]), .dime_req(auxIn[1]), .quarter_req(auxIn[2]),
        .restock(auxIn[3]), .err_clear(auxIn[4]),
        .nickel_sol(nickelSol2), .dime_sol(dimeSol2), .quarter_sol(quarterSol2),
        .busy(busy2), .queue_full(queueFull2), .overflow_err(overflowErr2), .short_err(shortErr2),
        .shortfall_cents(shortfallCents2),
        .nickel_cnt(nickelCnt2), .dime_cnt(dimeCnt2), .quarter_cnt(quarterCnt2)
    );

    always #5 clk = ~clk;

    // Count solenoid rising edges so pulse totals can be checked after a drain.
    always @(negedge clk) begin
        if (nickelSol && !prevN) nPulses++;
        if (dimeSol && !prevD) dPulses++;
        if (quarterSol && !prevQ) qPulses++;
        if (quarterSol2 && !prevQ2) q2Pulses++;
        prevN = nickelSol;
        prevD = dimeSol;
        prevQ = quarterSol;
        prevQ2 = quarterSol2;
    end

    task automatic applyStimulus(input logic [4:0] m, input logic [4:0] a);
        mainIn = m;
        auxIn = a;
        @(posedge clk);
        #1;
        mainIn = NONE;
        auxIn = NONE;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitMainIdle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            applyStimulus(NONE, NONE);
            n++;
        end
        checkOutput(tag, {31'd0, (n >= bound)}, 32'd0);
    endtask

    initial begin
        int n0, d0, q0, q20;
        logic [2:0] expSol;
        logic sawSol;

        $display("[TB] starting change_dispenser bench");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_sol", {29'd0, quarterSol, dimeSol, nickelSol}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_errs", {29'd0, queueFull, overflowErr, shortErr}, 32'd0);
        checkOutput("reset_shortfall", {25'd0, shortfallCents}, 32'd0);
        checkOutput("reset_nickel_cnt", {24'd0, nickelCnt}, 32'd20);
        checkOutput("reset_quarter_cnt", {24'd0, quarterCnt}, 32'd20);
        reset = 1'b0;
        applyStimulus(NONE, NONE);
        checkOutput("reset_dut2_quarter_cnt", {24'd0, quarterCnt2}, 32'd1);

        // Single quarter: 3-cycle pulse one edge after the request, then a 2-cycle gap.
        for (int t = 0; t <= 6; t++) begin
            applyStimulus((t == 0) ? QREQ : NONE, NONE);
            expSol = (t >= 1 && t <= 3) ? 3'b100 : 3'b000;
            checkOutput($sformatf("q_single_sol_t%0d", t), {29'd0, quarterSol, dimeSol, nickelSol}, {29'd0, expSol});
            checkOutput($sformatf("q_single_busy_t%0d", t), {31'd0, busy}, (t <= 5) ? 32'd1 : 32'd0);
        end
        checkOutput("q_single_cnt", {24'd0, quarterCnt}, 32'd19);

        // dime, nickel, dime on consecutive cycles: pulses start at t=1, 7, 13.
        for (int t = 0; t <= 18; t++) begin
            applyStimulus((t == 0 || t == 2) ? DREQ : ((t == 1) ? NREQ : NONE), NONE);
            if ((t >= 1 && t <= 3) || (t >= 13 && t <= 15)) expSol = 3'b010;
            else if (t >= 7 && t <= 9) expSol = 3'b001;
            else expSol = 3'b000;
            checkOutput($sformatf("dnd_sol_t%0d", t), {29'd0, quarterSol, dimeSol, nickelSol}, {29'd0, expSol});
        end
        checkOutput("dnd_dime_cnt", {24'd0, dimeCnt}, 32'd18);
        checkOutput("dnd_nickel_cnt", {24'd0, nickelCnt}, 32'd19);

        // 14 back-to-back nickels: pops at t=1 and t=7 keep room until t=9; t=10..12 drop;
        // t=13 is a push coinciding with a pop on a full FIFO. 11 accepted.
        n0 = nPulses;
        for (int t = 0; t <= 13; t++) begin
            applyStimulus(NREQ, NONE);
            if (t == 8) checkOutput("burst_full_t8", {31'd0, queueFull}, 32'd0);
            if (t == 9) begin
                checkOutput("burst_full_t9", {31'd0, queueFull}, 32'd1);
                checkOutput("burst_ovf_t9", {31'd0, overflowErr}, 32'd0);
            end
            if (t == 10) checkOutput("burst_ovf_t10", {31'd0, overflowErr}, 32'd1);
            if (t == 13) checkOutput("burst_full_t13", {31'd0, queueFull}, 32'd1);
        end
        waitMainIdle("burst_drain_timeout", 150);
        checkOutput("burst_pulses", nPulses - n0, 32'd11);
        checkOutput("burst_nickel_cnt", {24'd0, nickelCnt}, 32'd8);

        applyStimulus(ECLR, NONE);
        checkOutput("errclr_ovf", {31'd0, overflowErr}, 32'd0);

        // Simultaneous dime and quarter: only the quarter is kept.
        d0 = dPulses;
        q0 = qPulses;
        applyStimulus(DREQ | QREQ, NONE);
        checkOutput("multi_ovf", {31'd0, overflowErr}, 32'd1);
        waitMainIdle("multi_drain_timeout", 20);
        checkOutput("multi_q_pulses", qPulses - q0, 32'd1);
        checkOutput("multi_d_pulses", dPulses - d0, 32'd0);
        checkOutput("multi_quarter_cnt", {24'd0, quarterCnt}, 32'd18);

        // Restock on the same edge as a dime pop: counter lands on 20, pulse still runs.
        applyStimulus(DREQ, NONE);
        applyStimulus(RSTK, NONE);
        checkOutput("restock_sol", {31'd0, dimeSol}, 32'd1);
        checkOutput("restock_dime_cnt", {24'd0, dimeCnt}, 32'd20);
        checkOutput("restock_nickel_cnt", {24'd0, nickelCnt}, 32'd20);
        applyStimulus(NONE, NONE);
        applyStimulus(NONE, NONE);
        checkOutput("restock_sol_held", {31'd0, dimeSol}, 32'd1);
        applyStimulus(NONE, NONE);
        checkOutput("restock_sol_off", {31'd0, dimeSol}, 32'd0);
        waitMainIdle("restock_drain_timeout", 20);

        // INIT_COUNT=1 instance: second quarter is short 25 cents.
        q20 = q2Pulses;
        applyStimulus(NONE, QREQ);
        applyStimulus(NONE, QREQ);
        checkOutput("short_first_sol", {31'd0, quarterSol2}, 32'd1);
        checkOutput("short_first_cnt", {24'd0, quarterCnt2}, 32'd0);
        for (int t = 2; t <= 6; t++) applyStimulus(NONE, NONE);
        checkOutput("short_pre_err", {31'd0, shortErr2}, 32'd0);
        applyStimulus(NONE, NONE);
        checkOutput("short_err", {31'd0, shortErr2}, 32'd1);
        checkOutput("short_cents_25", {25'd0, shortfallCents2}, 32'd25);
        checkOutput("short_busy", {31'd0, busy2}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(NONE, QREQ);
            applyStimulus(NONE, NONE);
            checkOutput($sformatf("short_cents_k%0d", k), {25'd0, shortfallCents2},
                        (k == 5) ? 32'd127 : 32'(25 * (k + 1)));
        end
        checkOutput("short_q_pulses", q2Pulses - q20, 32'd1);
        checkOutput("short_cnt_floor", {24'd0, quarterCnt2}, 32'd0);

        // err_clear together with a new shortfall: the new event survives alone.
        applyStimulus(NONE, QREQ);
        applyStimulus(NONE, ECLR);
        checkOutput("clr_race_err", {31'd0, shortErr2}, 32'd1);
        checkOutput("clr_race_cents", {25'd0, shortfallCents2}, 32'd25);
        applyStimulus(NONE, ECLR);
        checkOutput("clr_err", {31'd0, shortErr2}, 32'd0);
        checkOutput("clr_cents", {25'd0, shortfallCents2}, 32'd0);

        // Reset during FIRE with three entries queued.
        for (int t = 0; t <= 3; t++) applyStimulus(NREQ, NONE);
        checkOutput("rst_pre_sol", {31'd0, nickelSol}, 32'd1);
        checkOutput("rst_pre_nickel_cnt", {24'd0, nickelCnt}, 32'd19);
        reset = 1'b1;
        #1;
        checkOutput("rst_sol_drop", {29'd0, quarterSol, dimeSol, nickelSol}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_nickel_cnt", {24'd0, nickelCnt}, 32'd20);
        checkOutput("rst_dime_cnt", {24'd0, dimeCnt}, 32'd20);
        checkOutput("rst_dut2_cnt", {24'd0, quarterCnt2}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n0 = nPulses;
        sawSol = 1'b0;
        for (int t = 0; t < 20; t++) begin
            applyStimulus(NONE, NONE);
            if (nickelSol || dimeSol || quarterSol || busy) sawSol = 1'b1;
        end
        checkOutput("rst_no_activity", {31'd0, sawSol}, 32'd0);
        checkOutput("rst_no_pulses", nPulses - n0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
